acl_spi_responder: RTL and testbench
====================================

Name: acl_spi_responder

Overview:
- SPI mode-0 slave that emulates the ADXL362 register interface, i.e. the device end of the accelerometer SPI link.
- Used as the on-board and simulation stand-in for the sensor, so the accelerometer master and display path can run without the physical part.
- Oversamples SCLK/CSN/MOSI with the system clock, decodes read and write frames, serves a 64-byte register map and drives MISO.

Parameters:
- DEVID_AD, 8'hAD, value of register 0x00.
- DEVID_MST, 8'h1D, value of register 0x01.
- PARTID, 8'hF2, value of register 0x02.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high.
- sclk  input  1  SPI clock from master; asynchronous; at most CLK100MHZ/8.
- mosi  input  1  master out, slave in.
- cs  input  1  active-low chip select.
- miso  output  1  slave out; driven 0 when not transmitting (no tristate).
- x_data  input  12  signed X sample to serve.
- y_data  input  12  signed Y sample to serve.
- z_data  input  12  signed Z sample to serve.
- power_ctl  output  8  current value of register 0x2D.
- wr_strobe  output  1  one-cycle pulse on every accepted register write.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, miso=0, wr_strobe=0, power_ctl=0x00, writable regs=0x00, bit counter=0, snapshot regs=0.
- Input sync: sclk, cs and mosi each pass through 2 flops. Edges are detected on the synced signals, so there is a fixed 3-cycle detect latency.
- Frame start: synced cs falls -> state=CMD, bitcnt=0, and x/y/z_data are latched into snapshot regs (one coherent sample per frame).
- Receive: on each detected sclk rise while cs is low, shift mosi in MSB-first; bitcnt wraps 0..7.
- CMD, 8th rise: 0x0B -> ADDR with mode=read; 0x0A -> ADDR with mode=write; any other value -> IGNORE.
- ADDR, 8th rise: addr <= rx[5:0] (bits 7:6 ignored); state=DATA. If mode=read, tx_shift <= reg[addr].
- DATA/read:
  - On each detected sclk fall: miso <= tx_shift[7]; tx_shift shifts left.
  - On the 8th rise of each byte: addr <= addr+1, wrapping 0x3F->0x00; tx_shift <= reg[new addr].
- DATA/write, 8th rise of each byte:
  - If addr is in 0x1F..0x2E, reg[addr] <= rx and wr_strobe pulses the next cycle.
  - Otherwise the write is dropped and wr_strobe stays 0.
  - In both cases addr <= addr+1 with wrap.
- IGNORE: miso=0; consume bits until cs rises.
- Register map:
  - 0x00-0x02: parameters.
  - 0x08/0x09/0x0A: x[11:4], y[11:4], z[11:4].
  - 0x0E/0x0F: x[7:0], {4{x[11]},x[11:8]}.
  - 0x10/0x11: same layout for y.
  - 0x12/0x13: same layout for z.
  - 0x1F-0x2E: writable, read back as written.
  - All other addresses read 0x00.
  - power_ctl mirrors reg 0x2D.
- Frame end or abort:
  - Synced cs rise in any state -> IDLE, miso=0 the next cycle, partial byte discarded.
  - A partial byte never writes.
- Simultaneous events: a cs rise detected in the same cycle as an sclk rise -> the cs rise wins and the bit is discarded.
- sclk edges while cs is high are ignored.
- Reset mid-frame returns to IDLE with reset values. A frame already in progress is not resumed; the next cs fall starts cleanly.

Decomposition:
- Shared package holds:
  - command codes: CMD_WRITE=8'h0A, CMD_READ=8'h0B;
  - register addresses: DEVID_AD 0x00, XDATA 0x08, XDATA_L 0x0E, POWER_CTL 0x2D;
  - writable-range bounds 0x1F/0x2E;
  - state enum IDLE/CMD/ADDR/DATA/IGNORE.
- One sub-module, spi_edge_sync, holds the 2-flop synchronizer plus rise/fall detection. It is instantiated for sclk and cs; mosi uses the synchronizer only.

Test Plan:
- Read DEVID burst: cs low; send 0x0B, 0x00, then clock 3 bytes -> MISO returns 0xAD, 0x1D, 0xF2; wr_strobe never pulses.
- Write POWER_CTL: send 0x0A, 0x2D, 0x02 -> exactly one wr_strobe pulse; power_ctl=0x02; a following 0x0B 0x2D read returns 0x02.
- Axis snapshot: x=0x7FF, y=0x800, z=0x001 at the cs fall, then change the inputs mid-frame; burst read from 0x0E -> 0xFF, 0x07, 0x00, 0xF8, 0x01, 0x00 (pre-change values).
- Read-only write and wrap: write 0x0A, 0x3F, 0x55, 0x66 -> both bytes dropped (0x3F and wrapped 0x00 are read-only); 0x00 still reads 0xAD; a read burst from 0x3F returns 0x00 then 0xAD.
- Abort: raise cs after 4 bits of a write data byte to 0x20 -> reg 0x20 unchanged; no wr_strobe; the next read frame is correct.
- Reset mid-frame: assert reset during ADDR -> miso=0 and power_ctl=0x00; after release, a DEVID read returns 0xAD.

Source files
------------

// File: rtl/acl_spi_responder_pkg.sv
// Shared constants, types and helpers for the ADXL362 SPI responder.
// Command codes, register addresses and the frame-level state encoding.
package acl_spi_responder_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;

    localparam logic [5:0] ADDR_DEVID_AD  = 6'h00;
    localparam logic [5:0] ADDR_DEVID_MST = 6'h01;
    localparam logic [5:0] ADDR_PARTID    = 6'h02;
    localparam logic [5:0] ADDR_XDATA     = 6'h08;
    localparam logic [5:0] ADDR_YDATA     = 6'h09;
    localparam logic [5:0] ADDR_ZDATA     = 6'h0A;
    localparam logic [5:0] ADDR_XDATA_L   = 6'h0E;
    localparam logic [5:0] ADDR_XDATA_H   = 6'h0F;
    localparam logic [5:0] ADDR_YDATA_L   = 6'h10;
    localparam logic [5:0] ADDR_YDATA_H   = 6'h11;
    localparam logic [5:0] ADDR_ZDATA_L   = 6'h12;
    localparam logic [5:0] ADDR_ZDATA_H   = 6'h13;
    localparam logic [5:0] ADDR_POWER_CTL = 6'h2D;

    localparam logic [5:0] ADDR_WR_LO = 6'h1F;
    localparam logic [5:0] ADDR_WR_HI = 6'h2E;
    localparam int         NUM_WR     = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_IGNORE
    } state_e;

    typedef enum logic {
        MODE_READ,
        MODE_WRITE
    } mode_e;

    function automatic logic is_writable(input logic [5:0] a);
        return (a >= ADDR_WR_LO) && (a <= ADDR_WR_HI);
    endfunction

    // High byte of a 12-bit sample sign-extended to 16 bits.
    function automatic logic [7:0] sext_hi(input logic [11:0] v);
        return {{4{v[11]}}, v[11:8]};
    endfunction

endpackage

// File: rtl/acl_spi_responder_spi_edge_sync.sv
// Two-flop synchronizer for an asynchronous SPI line plus edge detection
// on the synchronized value.
module spi_edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/acl_spi_responder.sv
// ADXL362-compatible SPI mode-0 slave: oversampled frame decoder,
// 64-byte register map with per-frame axis snapshot, MISO driver.
module acl_spi_responder
    import acl_spi_responder_pkg::*;
#(
    parameter logic [7:0] DEVID_AD  = 8'hAD,
    parameter logic [7:0] DEVID_MST = 8'h1D,
    parameter logic [7:0] PARTID    = 8'hF2
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs,
    output logic        miso,
    input  logic [11:0] x_data,
    input  logic [11:0] y_data,
    input  logic [11:0] z_data,
    output logic [7:0]  power_ctl,
    output logic        wr_strobe
);

    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_cs_rise;
    logic        w_cs_fall;
    logic        r_mosi_meta;
    logic        r_mosi_sync;

    state_e      r_state;
    state_e      w_state_nx;
    mode_e       r_mode;
    logic [2:0]  r_bitcnt;
    logic [7:0]  r_rx;
    logic [7:0]  w_rx_nx;
    logic [5:0]  r_addr;
    logic [5:0]  w_addr_inc;
    logic [5:0]  w_rd_addr;
    logic [7:0]  w_rd_data;
    logic [3:0]  w_rd_idx;
    logic [3:0]  w_wr_idx;
    logic [7:0]  r_tx;
    logic        r_miso;
    logic        r_wr_strobe;
    logic [7:0]  r_wregs [NUM_WR];
    logic [11:0] r_x;
    logic [11:0] r_y;
    logic [11:0] r_z;
    logic        w_bit;
    logic        w_byte_done;

    spi_edge_sync u_sclk_sync (
        .i_clk   (CLK100MHZ),
        .i_rst   (reset),
        .i_async (sclk),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_edge_sync u_cs_sync (
        .i_clk   (CLK100MHZ),
        .i_rst   (reset),
        .i_async (cs),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    // cs edges take priority over a coincident sclk rise.
    assign w_bit       = w_sclk_rise && !w_cs_rise && !w_cs_fall
                         && (r_state != ST_IDLE);
    assign w_byte_done = w_bit && (r_bitcnt == 3'd7);
    assign w_rx_nx     = {r_rx[6:0], r_mosi_sync};
    assign w_addr_inc  = r_addr + 6'd1;
    assign w_rd_addr   = (r_state == ST_ADDR) ? w_rx_nx[5:0] : w_addr_inc;
    assign w_rd_idx    = 4'(w_rd_addr - ADDR_WR_LO);
    assign w_wr_idx    = 4'(r_addr - ADDR_WR_LO);

    always_comb begin
        w_rd_data = 8'h00;
        case (w_rd_addr)
            ADDR_DEVID_AD:  w_rd_data = DEVID_AD;
            ADDR_DEVID_MST: w_rd_data = DEVID_MST;
            ADDR_PARTID:    w_rd_data = PARTID;
            ADDR_XDATA:     w_rd_data = r_x[11:4];
            ADDR_YDATA:     w_rd_data = r_y[11:4];
            ADDR_ZDATA:     w_rd_data = r_z[11:4];
            ADDR_XDATA_L:   w_rd_data = r_x[7:0];
            ADDR_XDATA_H:   w_rd_data = sext_hi(r_x);
            ADDR_YDATA_L:   w_rd_data = r_y[7:0];
            ADDR_YDATA_H:   w_rd_data = sext_hi(r_y);
            ADDR_ZDATA_L:   w_rd_data = r_z[7:0];
            ADDR_ZDATA_H:   w_rd_data = sext_hi(r_z);
            default: begin
                if (is_writable(w_rd_addr)) begin
                    w_rd_data = r_wregs[w_rd_idx];
                end
            end
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        if (w_cs_rise) begin
            w_state_nx = ST_IDLE;
        end else if (w_cs_fall) begin
            w_state_nx = ST_CMD;
        end else if (w_byte_done) begin
            case (r_state)
                ST_CMD: begin
                    if (w_rx_nx == CMD_READ || w_rx_nx == CMD_WRITE) begin
                        w_state_nx = ST_ADDR;
                    end else begin
                        w_state_nx = ST_IGNORE;
                    end
                end
                ST_ADDR: w_state_nx = ST_DATA;
                default: w_state_nx = r_state;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_mode      <= MODE_READ;
            r_bitcnt    <= 3'd0;
            r_rx        <= 8'h00;
            r_addr      <= 6'h00;
            r_tx        <= 8'h00;
            r_miso      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_x         <= 12'h000;
            r_y         <= 12'h000;
            r_z         <= 12'h000;
            for (int i = 0; i < NUM_WR; i++) begin
                r_wregs[i] <= 8'h00;
            end
        end else begin
            r_mosi_meta <= mosi;
            r_mosi_sync <= r_mosi_meta;
            r_wr_strobe <= 1'b0;
            if (w_cs_rise) begin
                r_bitcnt <= 3'd0;
                r_miso   <= 1'b0;
            end else if (w_cs_fall) begin
                r_bitcnt <= 3'd0;
                r_miso   <= 1'b0;
                r_x      <= x_data;
                r_y      <= y_data;
                r_z      <= z_data;
            end else begin
                if (w_bit) begin
                    r_rx     <= w_rx_nx;
                    r_bitcnt <= r_bitcnt + 3'd1;
                end
                if (w_byte_done) begin
                    case (r_state)
                        ST_CMD: begin
                            r_mode <= (w_rx_nx == CMD_WRITE) ? MODE_WRITE
                                                             : MODE_READ;
                        end
                        ST_ADDR: begin
                            r_addr <= w_rx_nx[5:0];
                            r_tx   <= w_rd_data;
                        end
                        ST_DATA: begin
                            r_addr <= w_addr_inc;
                            if (r_mode == MODE_READ) begin
                                r_tx <= w_rd_data;
                            end else if (is_writable(r_addr)) begin
                                r_wregs[w_wr_idx] <= w_rx_nx;
                                r_wr_strobe       <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                // Mode 0: present the next bit on the falling edge.
                if (w_sclk_fall && r_state == ST_DATA
                    && r_mode == MODE_READ) begin
                    r_miso <= r_tx[7];
                    r_tx   <= {r_tx[6:0], 1'b0};
                end
            end
        end
    end

    assign miso      = r_miso;
    assign wr_strobe = r_wr_strobe;
    assign power_ctl = r_wregs[4'(ADDR_POWER_CTL - ADDR_WR_LO)];

endmodule

// File: tb/tb_acl_spi_responder.sv
// Self-checking bench for acl_spi_responder: table of single-register reads,
// directed multi-frame corner cases, and randomized frames against a model.
module tb_acl_spi_responder;

    logic        CLK100MHZ = 1'b0;
    logic        reset;
    logic        sclk;
    logic        mosi;
    logic        cs;
    logic        miso;
    logic [11:0] x_data;
    logic [11:0] y_data;
    logic [11:0] z_data;
    logic [7:0]  power_ctl;
    logic        wr_strobe;

    acl_spi_responder dut (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs        (cs),
        .miso      (miso),
        .x_data    (x_data),
        .y_data    (y_data),
        .z_data    (z_data),
        .power_ctl (power_ctl),
        .wr_strobe (wr_strobe)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int nchecks = 0;
    int nerr = 0;
    int strobe_cnt = 0;
    int exp_strobes = 0;

    always @(posedge CLK100MHZ) begin
        if (wr_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
    end

    // Reference model: writable bytes and the axis sample taken at cs fall.
    logic [7:0]  m_wr [16];
    logic [11:0] sx, sy, sz;

    function automatic logic [7:0] m_read(input logic [5:0] a);
        logic signed [15:0] xs, ys, zs;
        xs = 16'($signed(sx));
        ys = 16'($signed(sy));
        zs = 16'($signed(sz));
        if (a >= 6'h1F && a <= 6'h2E) return m_wr[a - 6'h1F];
        case (a)
            6'h00: return 8'hAD;
            6'h01: return 8'h1D;
            6'h02: return 8'hF2;
            6'h08: return 8'(sx >> 4);
            6'h09: return 8'(sy >> 4);
            6'h0A: return 8'(sz >> 4);
            6'h0E: return xs[7:0];
            6'h0F: return xs[15:8];
            6'h10: return ys[7:0];
            6'h11: return ys[15:8];
            6'h12: return zs[7:0];
            6'h13: return zs[15:8];
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_write(input logic [5:0] a, input int n,
                               input logic [7:0] d [8]);
        logic [5:0] aa;
        for (int i = 0; i < n; i++) begin
            aa = a + 6'(i);
            if (aa >= 6'h1F && aa <= 6'h2E) begin
                m_wr[aa - 6'h1F] = d[i];
                exp_strobes++;
            end
        end
    endtask

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits,
                        output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            #80;
            sclk = 1'b1;
            rx = {rx[6:0], miso};
            #80;
            sclk = 1'b0;
        end
    endtask

    task automatic cs_start();
        @(negedge CLK100MHZ);
        cs = 1'b0;
        #100;
    endtask

    task automatic cs_end();
        #100;
        cs = 1'b1;
        #200;
    endtask

    task automatic read_frame(input logic [5:0] a, input int n,
                              input logic scramble,
                              output logic [7:0] got [8]);
        logic [7:0] d;
        for (int i = 0; i < 8; i++) got[i] = 8'h00;
        cs_start();
        xfer(8'h0B, 8, d);
        if (scramble) begin
            x_data = 12'($urandom);
            y_data = 12'($urandom);
            z_data = 12'($urandom);
        end
        xfer({2'b00, a}, 8, d);
        for (int i = 0; i < n; i++) begin
            xfer(8'h00, 8, d);
            got[i] = d;
        end
        cs_end();
    endtask

    task automatic write_frame(input logic [5:0] a, input int n,
                               input logic [7:0] wd [8]);
        logic [7:0] d;
        cs_start();
        xfer(8'h0A, 8, d);
        xfer({2'b00, a}, 8, d);
        for (int i = 0; i < n; i++) xfer(wd[i], 8, d);
        cs_end();
    endtask

    typedef struct {
        logic [5:0] addr;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl [15];
    logic [7:0] got [8];
    logic [7:0] wd [8];
    logic [7:0] d;
    logic [7:0] snap_exp [6];

    initial begin
        tbl[0]  = '{6'h00, 8'hAD};
        tbl[1]  = '{6'h01, 8'h1D};
        tbl[2]  = '{6'h02, 8'hF2};
        tbl[3]  = '{6'h08, 8'h12};
        tbl[4]  = '{6'h09, 8'hAB};
        tbl[5]  = '{6'h0A, 8'h80};
        tbl[6]  = '{6'h0E, 8'h23};
        tbl[7]  = '{6'h0F, 8'h01};
        tbl[8]  = '{6'h10, 8'hBC};
        tbl[9]  = '{6'h11, 8'hFA};
        tbl[10] = '{6'h12, 8'h00};
        tbl[11] = '{6'h13, 8'hF8};
        tbl[12] = '{6'h05, 8'h00};
        tbl[13] = '{6'h3F, 8'h00};
        tbl[14] = '{6'h2D, 8'h00};
        for (int i = 0; i < 8; i++) wd[i] = 8'h00;
        for (int i = 0; i < 16; i++) m_wr[i] = 8'h00;

        reset = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        x_data = 12'h123; y_data = 12'hABC; z_data = 12'h800;
        repeat (5) @(negedge CLK100MHZ);
        check("reset miso", 32'(miso), 32'h0);
        check("reset power_ctl", 32'(power_ctl), 32'h0);
        check("reset wr_strobe", 32'(wr_strobe), 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge CLK100MHZ);

        for (int i = 0; i < 15; i++) begin
            read_frame(tbl[i].addr, 1, 1'b0, got);
            check($sformatf("tbl[%0d] addr %0h", i, tbl[i].addr),
                  32'(got[0]), 32'(tbl[i].exp));
        end

        read_frame(6'h00, 3, 1'b0, got);
        check("devid burst 0", 32'(got[0]), 32'hAD);
        check("devid burst 1", 32'(got[1]), 32'h1D);
        check("devid burst 2", 32'(got[2]), 32'hF2);
        check("devid no strobe", 32'(strobe_cnt), 32'h0);

        wd[0] = 8'h02;
        write_frame(6'h2D, 1, wd);
        model_write(6'h2D, 1, wd);
        check("power_ctl strobe", 32'(strobe_cnt), 32'(exp_strobes));
        check("power_ctl value", 32'(power_ctl), 32'h02);
        read_frame(6'h2D, 1, 1'b0, got);
        check("power_ctl readback", 32'(got[0]), 32'h02);

        x_data = 12'h7FF; y_data = 12'h800; z_data = 12'h001;
        snap_exp = '{8'hFF, 8'h07, 8'h00, 8'hF8, 8'h01, 8'h00};
        cs_start();
        xfer(8'h0B, 8, d);
        x_data = 12'h000; y_data = 12'h123; z_data = 12'hFFF;
        xfer(8'h0E, 8, d);
        for (int i = 0; i < 6; i++) begin
            xfer(8'h00, 8, d);
            check($sformatf("snapshot byte %0d", i), 32'(d),
                  32'(snap_exp[i]));
        end
        cs_end();

        wd[0] = 8'h55; wd[1] = 8'h66;
        write_frame(6'h3F, 2, wd);
        model_write(6'h3F, 2, wd);
        check("ro write strobe", 32'(strobe_cnt), 32'(exp_strobes));
        read_frame(6'h00, 1, 1'b0, got);
        check("ro devid intact", 32'(got[0]), 32'hAD);
        read_frame(6'h3F, 2, 1'b0, got);
        check("wrap read 3f", 32'(got[0]), 32'h00);
        check("wrap read 00", 32'(got[1]), 32'hAD);

        wd[0] = 8'h5A;
        write_frame(6'h20, 1, wd);
        model_write(6'h20, 1, wd);
        cs_start();
        xfer(8'h0A, 8, d);
        xfer(8'h20, 8, d);
        xfer(8'hFF, 4, d);
        cs_end();
        check("abort strobe", 32'(strobe_cnt), 32'(exp_strobes));
        read_frame(6'h20, 1, 1'b0, got);
        check("abort reg 20", 32'(got[0]), 32'h5A);
        read_frame(6'h01, 1, 1'b0, got);
        check("after abort read", 32'(got[0]), 32'h1D);

        cs_start();
        xfer(8'h0B, 8, d);
        xfer(8'h00, 3, d);
        @(negedge CLK100MHZ);
        reset = 1'b1;
        repeat (4) @(negedge CLK100MHZ);
        check("midreset miso", 32'(miso), 32'h0);
        check("midreset power_ctl", 32'(power_ctl), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) m_wr[i] = 8'h00;
        xfer(8'h00, 5, d);
        xfer(8'h00, 8, d);
        check("midreset stale miso", 32'(d), 32'h0);
        cs_end();
        read_frame(6'h00, 1, 1'b0, got);
        check("postreset devid", 32'(got[0]), 32'hAD);
        read_frame(6'h20, 1, 1'b0, got);
        check("postreset reg 20", 32'(got[0]), 32'h00);
        exp_strobes = strobe_cnt;

        for (int f = 0; f < 25; f++) begin
            int         kind;
            int         n;
            logic [5:0] a;
            logic [7:0] cmd;
            kind = $urandom_range(0, 9);
            n = $urandom_range(1, 4);
            a = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(28, 49))
                                            : 6'($urandom);
            x_data = 12'($urandom);
            y_data = 12'($urandom);
            z_data = 12'($urandom);
            sx = x_data; sy = y_data; sz = z_data;
            if (kind < 5) begin
                read_frame(a, n, 1'b1, got);
                for (int i = 0; i < n; i++) begin
                    check($sformatf("rand rd f%0d a%0h", f, a + 6'(i)),
                          32'(got[i]), 32'(m_read(a + 6'(i))));
                end
            end else if (kind < 9) begin
                for (int i = 0; i < 8; i++) wd[i] = 8'($urandom);
                write_frame(a, n, wd);
                model_write(a, n, wd);
                check($sformatf("rand wr strobe f%0d", f),
                      32'(strobe_cnt), 32'(exp_strobes));
                check($sformatf("rand wr power_ctl f%0d", f),
                      32'(power_ctl), 32'(m_wr[14]));
            end else begin
                cmd = 8'($urandom);
                if (cmd == 8'h0A || cmd == 8'h0B) cmd = 8'h3C;
                cs_start();
                xfer(cmd, 8, d);
                xfer({2'b00, a}, 8, d);
                for (int i = 0; i < n; i++) begin
                    xfer(8'($urandom), 8, d);
                    check($sformatf("ignore miso f%0d", f), 32'(d), 32'h0);
                end
                cs_end();
                check($sformatf("ignore strobe f%0d", f),
                      32'(strobe_cnt), 32'(exp_strobes));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerr);
        $finish;
    end

endmodule
